// File: rtl/ddr_latency_pipe_pkg.sv
// Shared latency definitions for the controller-side and memory-side delay lines.
package ddr_latency_pipe_pkg;

  // Largest supported CAS latency and CAS write latency, in clocks.
  localparam int MAX_CL  = 24;
  localparam int MAX_CWL = 20;
  // Default CAS latency after power-up.
  localparam int DEF_TCL = 11;

  // The controller retimes read data at TCL-1 and the memory model at TCL-2.
  localparam int CTRL_LAT_OFS = 1;
  localparam int MEM_LAT_OFS  = 2;

  localparam int DEF_MAXLAT = (MAX_CL > MAX_CWL) ? MAX_CL : MAX_CWL;
  localparam int DEF_RSTLAT = DEF_TCL;
  localparam int DEF_LATW   = $clog2(DEF_MAXLAT + 1);

  typedef logic [DEF_LATW-1:0] lat_t;

  // Converts a mode-register CAS latency into a pipe latency for a given side.
  function automatic lat_t tcl_to_lat(input int tcl, input int ofs);
    return lat_t'(tcl - ofs);
  endfunction

endpackage

// File: rtl/ddr_latency_ctrl.sv
// Reload guard, occupancy counter and reload-error pulse for ddr_latency_pipe.
module ddr_latency_ctrl
  import ddr_latency_pipe_pkg::*;
#(
  parameter int MAXLAT = DEF_MAXLAT,
  parameter int MINLAT = 1,
  parameter int RSTLAT = DEF_RSTLAT,
  parameter int LATW   = $clog2(MAXLAT + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            flush,
  input  logic            tap_vld,
  input  logic            lat_load,
  input  logic [LATW-1:0] lat_cfg,
  output logic            load_acc,
  output logic [LATW-1:0] cur_lat,
  output logic [LATW-1:0] occupancy,
  output logic            empty,
  output logic            lat_err
);

  logic cfg_ok;

  assign cfg_ok   = (lat_cfg >= LATW'(MINLAT)) && (lat_cfg <= LATW'(MAXLAT));
  assign empty    = (occupancy == '0);
  // A new latency is only safe when nothing is in flight and no flush competes.
  assign load_acc = lat_load && empty && cfg_ok && !flush;

  // Latency register, occupancy count and one-cycle rejection pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_lat   <= LATW'(RSTLAT);
      occupancy <= '0;
      lat_err   <= 1'b0;
    end else begin
      lat_err <= lat_load && !load_acc;
      if (load_acc)
        cur_lat <= lat_cfg;
      if (flush)
        occupancy <= '0;
      else
        occupancy <= occupancy + LATW'(in_valid) - LATW'(tap_vld);
    end
  end

endmodule

// File: rtl/ddr_latency_pipe.sv
// Runtime-programmable fixed-latency {valid, data} delay line with flush and guarded reload.
module ddr_latency_pipe
  import ddr_latency_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MAXLAT = DEF_MAXLAT,
  parameter int MINLAT = 1,
  parameter int RSTLAT = DEF_RSTLAT,
  parameter int LATW   = $clog2(MAXLAT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic             lat_load,
  input  logic [LATW-1:0]  lat_cfg,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [LATW-1:0]  cur_lat,
  output logic [LATW-1:0]  occupancy,
  output logic             empty,
  output logic             lat_err
);

  if (MINLAT < 1 || MINLAT > MAXLAT || RSTLAT < MINLAT || RSTLAT > MAXLAT) begin : g_param_check
    $fatal(1, "ddr_latency_pipe: require 1 <= MINLAT <= RSTLAT <= MAXLAT");
  end

  logic [MAXLAT-1:0] stg_vld;
  logic [WIDTH-1:0]  stg_data [MAXLAT];
  logic              tap_vld;
  logic [WIDTH-1:0]  tap_data;
  logic              load_acc;
  logic              wr;
  logic              clr;

  assign wr  = in_valid && !flush;
  // Clearing on an accepted load kills stale valids of words that already left
  // through the old tap, so a longer latency cannot replay them.
  assign clr = flush || load_acc;

  ddr_latency_ctrl #(
    .MAXLAT (MAXLAT),
    .MINLAT (MINLAT),
    .RSTLAT (RSTLAT),
    .LATW   (LATW)
  ) u_ctrl (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .flush     (flush),
    .tap_vld   (tap_vld),
    .lat_load  (lat_load),
    .lat_cfg   (lat_cfg),
    .load_acc  (load_acc),
    .cur_lat   (cur_lat),
    .occupancy (occupancy),
    .empty     (empty),
    .lat_err   (lat_err)
  );

  // Tap select: stage cur_lat-1 feeds the output register.
  always_comb begin
    tap_vld  = 1'b0;
    tap_data = '0;
    for (int i = 0; i < MAXLAT; i++) begin
      if (cur_lat == LATW'(i + 1)) begin
        tap_vld  = stg_vld[i];
        tap_data = stg_data[i];
      end
    end
  end

  // Shift chain and registered output tap.
  always_ff @(posedge clock) begin
    if (reset) begin
      stg_vld   <= '0;
      for (int i = 0; i < MAXLAT; i++)
        stg_data[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      for (int i = MAXLAT - 1; i > 0; i--) begin
        stg_vld[i]  <= stg_vld[i-1] && !clr;
        stg_data[i] <= stg_data[i-1];
      end
      stg_vld[0]  <= wr;
      stg_data[0] <= wr ? in_data : '0;
      out_valid   <= tap_vld && !flush;
      out_data    <= (tap_vld && !flush) ? tap_data : '0;
    end
  end

`ifndef SYNTHESIS
  // Input sanity and occupancy bound.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(in_valid === 1'b1 && $isunknown(in_data)))
        else $fatal(1, "ddr_latency_pipe: in_data unknown while in_valid=1");
      assert (!$isunknown({in_valid, flush, lat_load, lat_cfg}))
        else $fatal(1, "ddr_latency_pipe: control input unknown");
      assert (occupancy <= cur_lat)
        else $fatal(1, "ddr_latency_pipe: occupancy exceeds cur_lat");
    end
  end
`endif

endmodule

// File: doc/ddr_latency_pipe.md
Name: ddr_latency_pipe

Overview:
- Parametrised, runtime-programmable fixed-latency delay line carrying {valid, data} words.
- Supersedes the hard-wired CL-based shift registers on the controller and memory sides. One instance per timing path: read-data return (CL), write-data launch (CWL), ODT/command echo.
- Latency is loaded from the mode-register value at MRS time.
- Adds the following, which fixed delays do not have:
  - occupancy tracking
  - guarded latency reload
  - flush
  - an error report

Parameters:
- WIDTH, 64, payload bits per word.
- MAXLAT, 24, largest programmable latency in clocks; sets physical stage count.
- MINLAT, 1, smallest legal latency; must satisfy 1 <= MINLAT <= MAXLAT.
- RSTLAT, 11, latency value after reset; must satisfy MINLAT <= RSTLAT <= MAXLAT.
- LATW, $clog2(MAXLAT+1), width of latency and occupancy fields (derived).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  word present this cycle.
- in_data  in  WIDTH  payload; ignored when in_valid=0.
- flush  in  1  discard every word in flight.
- lat_load  in  1  request to adopt lat_cfg.
- lat_cfg  in  LATW  requested latency in clocks.
- out_valid  out  1  delayed valid.
- out_data  out  WIDTH  delayed payload; 0 when out_valid=0.
- cur_lat  out  LATW  latency currently in force.
- occupancy  out  LATW  words in flight.
- empty  out  1  occupancy==0.
- lat_err  out  1  one-cycle pulse: lat_load rejected.

Behaviour:
- Reset (synchronous, active-high):
  - All stages cleared.
  - out_valid=0, out_data=0, occupancy=0, empty=1, lat_err=0, cur_lat=RSTLAT.
  - Reset mid-operation discards all words in flight with no output.
- Latency:
  - A word sampled with in_valid=1 at edge k appears on out_valid/out_data for exactly one cycle, following edge k+cur_lat.
  - Back-to-back inputs produce back-to-back outputs, in order, with no bubbles.
- Storage:
  - MAXLAT registered stages of {valid, data}; the output is a registered tap selected by cur_lat.
  - A stage written with in_valid=0 stores data=0.
  - No combinational path from in_* to out_*.
- Occupancy:
  - +1 on an accepted input, -1 on an output, unchanged when both occur in one cycle.
  - Never exceeds cur_lat.
  - empty is derived directly from occupancy.
- Latency reload (sampled when lat_load=1):
  - The load is accepted when all three hold: empty=1, MINLAT <= lat_cfg <= MAXLAT, flush=0. cur_lat takes lat_cfg at that edge.
  - An in_valid in the same cycle as an accepted load is delayed by the new latency.
  - Otherwise the load is rejected. cur_lat is unchanged, lat_err=1 for one cycle, and the words in flight are unaffected.
- Flush:
  - At the edge, every stage's valid bit is cleared and occupancy goes to 0.
  - Any in_valid in the same cycle is dropped.
  - out_valid=0 from the following cycle until a new word matures.
  - flush together with lat_load is always a rejection.
- Simulation-only assertions, each $fatal on failure:
  - in_data must not be unknown while in_valid=1.
  - Control inputs must not be unknown outside reset.
  - occupancy must not exceed cur_lat.
- Elaboration check: $fatal if the parameter constraints are violated.

Decomposition:
- Shared package (Definitions.pkg):
  - default MAXLAT derived from the largest supported CL/CWL;
  - RSTLAT derived from the default TCL;
  - a latency typedef of LATW bits;
  - constants for the controller and memory latency offsets. The controller uses TCL-1 and the memory uses TCL-2, so both instantiate this block with differing lat_cfg.
- Sub-module: ddr_latency_ctrl, holding the reload guard, occupancy counter and lat_err generation. The datapath stages and tap mux stay in the top.

Test Plan:
1. Reset, then in_valid=1 with data 0xA5 at edge 0, RSTLAT=11 -> out_valid=1 with 0xA5 only in the cycle after edge 11; occupancy goes 1 then 0; empty returns to 1.
2. 5 consecutive words 1..5, cur_lat=11 -> outputs 1..5 on 5 consecutive cycles starting at edge 11; peak occupancy=5; out_data=0 between bursts.
3. Pipe empty, lat_load=1, lat_cfg=4, in_valid=1 with data 0x3C in the same cycle -> cur_lat=4, 0x3C emerges after edge 4, lat_err stays 0.
4. Reload rejections -> lat_err pulses one cycle, cur_lat unchanged, in-flight words exit on time:
   - occupancy=2, lat_load=1, lat_cfg=6;
   - empty pipe with lat_cfg=0;
   - empty pipe with lat_cfg=MAXLAT+1.
5. 3 words in flight, then flush with in_valid=1 (data 0x77) -> no output for the 3 words or 0x77; occupancy=0, empty=1 next cycle.
6. Reset asserted with 4 words in flight, cur_lat=4 -> all outputs suppressed, cur_lat returns to RSTLAT=11; inputs after reset are delayed by 11.
